// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// Memory-access pipeline stage that sits directly after the execute stage.
//
// For loads and stores the execute result is the byte address. An aligned
// access is captured into a request register and driven to the data memory
// through a request/response handshake. The stage holds upstream with
// M_stall_o while the access is in flight. Load data is selected by byte or
// halfword lane and sign- or zero-extended. Every completed instruction then
// lands in a registered result bank for write-back.
//
// A misaligned access never reaches memory. It completes one cycle later
// with M_misalign_o set and the register write suppressed. Any other valid
// instruction passes straight through to the result bank.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   E_valid_i      execute-stage instruction valid
//   E_op_load_i    instruction is a load
//   E_op_store_i   instruction is a store
//   E_funct3_i     access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   E_valE_i       ALU result (byte address for memory ops)
//   E_rs2_data_i   store data
//   E_rd_i         destination register
//   E_wen_i        register write enable
//   dmem_req_o     memory request, held until dmem_ready_i
//   dmem_we_o      1 = write
//   dmem_addr_o    word-aligned address
//   dmem_wstrb_o   byte strobes (all zero for loads)
//   dmem_wdata_o   lane-replicated store data
//   dmem_ready_i   memory accepts the request this cycle
//   dmem_rvalid_i  read data valid
//   dmem_rdata_i   read word
//   M_stall_o      combinational hold request to upstream
//   M_valid_o      one-cycle pulse per completed instruction
//   M_valE_o       registered execute result / address
//   M_valM_o       registered extended load data (0 for non-loads)
//   M_rd_o         registered destination register
//   M_wen_o        registered write enable
//   M_misalign_o   registered misaligned-access flag
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            E_valid_i,
    input  logic            E_op_load_i,
    input  logic            E_op_store_i,
    input  logic [2:0]      E_funct3_i,
    input  logic [XLEN-1:0] E_valE_i,
    input  logic [XLEN-1:0] E_rs2_data_i,
    input  logic [4:0]      E_rd_i,
    input  logic            E_wen_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_wstrb_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            M_stall_o,
    output logic            M_valid_o,
    output logic [XLEN-1:0] M_valE_o,
    output logic [XLEN-1:0] M_valM_o,
    output logic [4:0]      M_rd_o,
    output logic            M_wen_o,
    output logic            M_misalign_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // -------------------------------------------------------------------------
    // Data formatting helpers
    // -------------------------------------------------------------------------

    // Halfwords must sit on an even byte and words on a word boundary.
    // Size code 11 is not a legal access and is treated like a word.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] a);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                                input logic [1:0] a);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << a;
            2'b01:   strb = 4'b0011 << a;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the store value across all lanes so the strobes alone pick
    // the destination bytes.
    function automatic logic [XLEN-1:0] store_data(input logic [2:0]      funct3,
                                                   input logic [XLEN-1:0] rs2);
        logic [XLEN-1:0] wd;
        case (funct3[1:0])
            2'b00:   wd = {4{rs2[7:0]}};
            2'b01:   wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                    input logic [1:0]      a,
                                                    input logic [XLEN-1:0] rdata);
        logic [7:0]      lane_b;
        logic [15:0]     lane_h;
        logic [XLEN-1:0] res;
        case (a)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            2'b11:   lane_b = rdata[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = a[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  res = {{24{lane_b[7]}}, lane_b};
            3'b001:  res = {{16{lane_h[15]}}, lane_h};
            3'b100:  res = {24'h000000, lane_b};
            3'b101:  res = {16'h0000, lane_h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t          state_r;
    state_t          state_s;

    logic [XLEN-1:0] addr_r;
    logic [2:0]      funct3_r;
    logic [XLEN-1:0] wdata_r;
    logic [3:0]      wstrb_r;
    logic [4:0]      rd_r;
    logic            wen_r;
    logic            store_r;
    logic            req_r;

    logic            m_valid_r;
    logic [XLEN-1:0] m_vale_r;
    logic [XLEN-1:0] m_valm_r;
    logic [4:0]      m_rd_r;
    logic            m_wen_r;
    logic            m_misalign_r;

    // -------------------------------------------------------------------------
    // Instruction decode
    // -------------------------------------------------------------------------
    logic is_mem_s;
    logic is_store_s;
    logic misalign_s;

    // A request with both op bits set is handled as a load.
    assign is_mem_s   = E_op_load_i | E_op_store_i;
    assign is_store_s = E_op_store_i & ~E_op_load_i;
    assign misalign_s = is_mem_s & is_misaligned(E_funct3_i, E_valE_i[1:0]);

    // -------------------------------------------------------------------------
    // Next-state, capture, stall and result-load decisions
    // -------------------------------------------------------------------------
    logic            cap_s;
    logic            stall_s;
    logic            res_load_s;
    logic [XLEN-1:0] res_vale_s;
    logic [XLEN-1:0] res_valm_s;
    logic [4:0]      res_rd_s;
    logic            res_wen_s;
    logic            res_misalign_s;

    // FSM next state plus everything that depends on it
    always_comb begin
        state_s        = state_r;
        cap_s          = 1'b0;
        stall_s        = 1'b0;
        res_load_s     = 1'b0;
        res_vale_s     = E_valE_i;
        res_valm_s     = {XLEN{1'b0}};
        res_rd_s       = E_rd_i;
        res_wen_s      = E_wen_i;
        res_misalign_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (E_valid_i) begin
                    if (!is_mem_s) begin
                        res_load_s = 1'b1;
                    end else if (misalign_s) begin
                        res_load_s     = 1'b1;
                        res_wen_s      = 1'b0;
                        res_misalign_s = 1'b1;
                    end else begin
                        cap_s   = 1'b1;
                        stall_s = 1'b1;
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Any read-valid seen while the request is still pending is
                // stale and deliberately ignored here.
                if (dmem_ready_i) begin
                    if (store_r) begin
                        res_load_s = 1'b1;
                        res_vale_s = addr_r;
                        res_rd_s   = rd_r;
                        res_wen_s  = wen_r;
                        state_s    = ST_IDLE;
                    end else begin
                        stall_s = 1'b1;
                        state_s = ST_WAIT;
                    end
                end else begin
                    stall_s = 1'b1;
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    res_load_s = 1'b1;
                    res_vale_s = addr_r;
                    res_valm_s = load_extend(funct3_r, addr_r[1:0], dmem_rdata_i);
                    res_rd_s   = rd_r;
                    res_wen_s  = wen_r;
                    state_s    = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request register: captured once on accept and then held stable for
    // the whole handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r   <= {XLEN{1'b0}};
            funct3_r <= 3'b000;
            wdata_r  <= {XLEN{1'b0}};
            wstrb_r  <= 4'b0000;
            rd_r     <= 5'd0;
            wen_r    <= 1'b0;
            store_r  <= 1'b0;
        end else if (cap_s) begin
            addr_r   <= E_valE_i;
            funct3_r <= E_funct3_i;
            wdata_r  <= store_data(E_funct3_i, E_rs2_data_i);
            wstrb_r  <= is_store_s ? store_strobe(E_funct3_i, E_valE_i[1:0]) : 4'b0000;
            rd_r     <= E_rd_i;
            wen_r    <= E_wen_i;
            store_r  <= is_store_s;
        end else begin
            addr_r   <= addr_r;
            funct3_r <= funct3_r;
            wdata_r  <= wdata_r;
            wstrb_r  <= wstrb_r;
            rd_r     <= rd_r;
            wen_r    <= wen_r;
            store_r  <= store_r;
        end
    end

    // Request strobe, registered from the next state so it mirrors REQ exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_r <= 1'b0;
        end else begin
            req_r <= (state_s == ST_REQ);
        end
    end

    // Result register; payload fields hold between completions, valid pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_r    <= 1'b0;
            m_vale_r     <= {XLEN{1'b0}};
            m_valm_r     <= {XLEN{1'b0}};
            m_rd_r       <= 5'd0;
            m_wen_r      <= 1'b0;
            m_misalign_r <= 1'b0;
        end else begin
            m_valid_r <= res_load_s;
            if (res_load_s) begin
                m_vale_r     <= res_vale_s;
                m_valm_r     <= res_valm_s;
                m_rd_r       <= res_rd_s;
                m_wen_r      <= res_wen_s;
                m_misalign_r <= res_misalign_s;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign dmem_req_o   = req_r;
    assign dmem_we_o    = store_r;
    assign dmem_addr_o  = {addr_r[XLEN-1:2], 2'b00};
    assign dmem_wstrb_o = wstrb_r;
    assign dmem_wdata_o = wdata_r;

    // Stall is masked while reset is asserted so upstream never sees a hold
    // coming from pre-reset state.
    assign M_stall_o    = stall_s & rst_n;

    assign M_valid_o    = m_valid_r;
    assign M_valE_o     = m_vale_r;
    assign M_valM_o     = m_valm_r;
    assign M_rd_o       = m_rd_r;
    assign M_wen_o      = m_wen_r;
    assign M_misalign_o = m_misalign_r;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//
// Randomised bench for mem_access. The driver steps one instruction at a
// time and plays the memory side with random ready/rvalid latencies. It
// predicts each cycle's stall, request and result from the access rules:
// lane arithmetic for strobes, data and extension, plus the latency of each
// access class. One negedge process compares the DUT against those
// predictions.
// -----------------------------------------------------------------------------
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        E_valid_i, E_op_load_i, E_op_store_i, E_wen_i;
    logic [2:0]  E_funct3_i;
    logic [31:0] E_valE_i, E_rs2_data_i;
    logic [4:0]  E_rd_i;
    logic        dmem_req_o, dmem_we_o, dmem_ready_i, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_wstrb_o;
    logic        M_stall_o, M_valid_o, M_wen_o, M_misalign_o;
    logic [31:0] M_valE_o, M_valM_o;
    logic [4:0]  M_rd_o;

    always #5 clk = ~clk;

    mem_access #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_valid_i(E_valid_i), .E_op_load_i(E_op_load_i), .E_op_store_i(E_op_store_i),
        .E_funct3_i(E_funct3_i), .E_valE_i(E_valE_i), .E_rs2_data_i(E_rs2_data_i),
        .E_rd_i(E_rd_i), .E_wen_i(E_wen_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wstrb_o(dmem_wstrb_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .M_stall_o(M_stall_o), .M_valid_o(M_valid_o), .M_valE_o(M_valE_o),
        .M_valM_o(M_valM_o), .M_rd_o(M_rd_o), .M_wen_o(M_wen_o), .M_misalign_o(M_misalign_o)
    );

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    // Expectations for the current cycle
    logic        exp_stall, exp_req, exp_we, exp_mvalid, exp_wen, exp_mis;
    logic [31:0] exp_addr, exp_wdata, exp_vale, exp_valm;
    logic [3:0]  exp_wstrb;
    logic [4:0]  exp_rd;

    // Result predicted for the following cycle
    logic        pend_valid = 1'b0;
    logic        pend_wen, pend_mis;
    logic [31:0] pend_vale, pend_valm;
    logic [4:0]  pend_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model (access rules) ----------------
    function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int sz = int'(f3) % 4;
        int a  = int'(addr % 4);
        if (sz == 0) return 1'b0;
        if (sz == 1) return (a % 2) != 0;
        return a != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
        int sz = int'(f3) % 4;
        int a  = int'(addr % 4);
        if (ld) return 4'd0;
        if (sz == 0) return 4'd1 << a;
        if (sz == 1) return 4'd3 << a;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int sz = int'(f3) % 4;
        if (sz == 0) return (rs2 % 256) * 32'h01010101;
        if (sz == 1) return (rs2 % 65536) * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int sz = int'(f3) % 4;
        int a  = int'(addr % 4);
        logic [31:0] v;
        if (sz == 0) begin
            v = (rdata >> (8 * a)) % 256;
            if (f3 < 3'd4 && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 1) begin
            v = (rdata >> (16 * (a / 2))) % 65536;
            if (f3 < 3'd4 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        exp_mvalid = pend_valid;
        if (pend_valid) begin
            exp_vale = pend_vale; exp_valm = pend_valm; exp_rd = pend_rd;
            exp_wen  = pend_wen;  exp_mis  = pend_mis;
        end
        pend_valid    = 1'b0;
        dmem_ready_i  = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = $urandom;
        exp_req       = 1'b0;
        exp_stall     = 1'b0;
    endtask

    task automatic set_result(input logic [31:0] va, input logic [31:0] vm, input logic [4:0] rd,
                              input logic wen, input logic mis);
        pend_valid = 1'b1; pend_vale = va; pend_valm = vm;
        pend_rd = rd; pend_wen = wen; pend_mis = mis;
    endtask

    task automatic idle_cycle();
        begin_cycle();
        E_valid_i    = 1'b0;
        E_op_load_i  = 1'($urandom);
        E_op_store_i = 1'($urandom);
        E_funct3_i   = 3'($urandom);
        E_valE_i     = $urandom;
        E_rd_i       = 5'($urandom);
        E_wen_i      = 1'($urandom);
    endtask

    task automatic run_instr(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] va, input logic [31:0] rs2, input logic [4:0] rd,
                             input logic wen, input int rdly, input int vdly,
                             input logic [31:0] rdata, input logic abort);
        logic mem, mis;
        begin_cycle();
        E_valid_i = 1'b1; E_op_load_i = ld; E_op_store_i = st; E_funct3_i = f3;
        E_valE_i = va; E_rs2_data_i = rs2; E_rd_i = rd; E_wen_i = wen;
        mem = ld | st;
        mis = mem & m_misaligned(f3, va);
        if (!mem || mis) begin
            set_result(va, 32'd0, rd, mis ? 1'b0 : wen, mis);
            return;
        end
        exp_stall = 1'b1;
        for (int i = 0; i <= rdly; i++) begin
            begin_cycle();
            exp_req = 1'b1; exp_we = st; exp_addr = {va[31:2], 2'b00};
            exp_wstrb = m_strb(ld, f3, va); exp_wdata = m_wdata(f3, rs2);
            dmem_ready_i  = (i == rdly);
            dmem_rvalid_i = 1'($urandom);
            if (st && i == rdly) begin
                exp_stall = 1'b0;
                set_result(va, 32'd0, rd, wen, 1'b0);
            end else begin
                exp_stall = 1'b1;
            end
        end
        if (!ld) return;
        if (abort) begin
            begin_cycle();
            rst_n = 1'b0; E_valid_i = 1'b0;
            begin_cycle();
            rst_n = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
            return;
        end
        for (int j = 1; j <= vdly; j++) begin
            begin_cycle();
            if (j == vdly) begin
                dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
                set_result(va, m_ext(f3, va, rdata), rd, wen, 1'b0);
            end else begin
                exp_stall = 1'b1;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"},   {31'd0, dmem_req_o},   32'd0);
        chk({tag, "_we"},    {31'd0, dmem_we_o},    32'd0);
        chk({tag, "_addr"},  dmem_addr_o,           32'd0);
        chk({tag, "_wstrb"}, {28'd0, dmem_wstrb_o}, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata_o,          32'd0);
        chk({tag, "_stall"}, {31'd0, M_stall_o},    32'd0);
        chk({tag, "_valid"}, {31'd0, M_valid_o},    32'd0);
        chk({tag, "_vale"},  M_valE_o,              32'd0);
        chk({tag, "_valm"},  M_valM_o,              32'd0);
        chk({tag, "_rd"},    {27'd0, M_rd_o},       32'd0);
        chk({tag, "_wen"},   {31'd0, M_wen_o},      32'd0);
        chk({tag, "_mis"},   {31'd0, M_misalign_o}, 32'd0);
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("stall", {31'd0, M_stall_o},  {31'd0, exp_stall});
            chk("req",   {31'd0, dmem_req_o}, {31'd0, exp_req});
            chk("mvalid",{31'd0, M_valid_o},  {31'd0, exp_mvalid});
            if (exp_req) begin
                chk("we",    {31'd0, dmem_we_o},    {31'd0, exp_we});
                chk("addr",  dmem_addr_o,           exp_addr);
                chk("wstrb", {28'd0, dmem_wstrb_o}, {28'd0, exp_wstrb});
                if (exp_we) chk("wdata", dmem_wdata_o, exp_wdata);
            end
            if (exp_mvalid) begin
                chk("vale", M_valE_o, exp_vale);
                chk("valm", M_valM_o, exp_valm);
                chk("rd",   {27'd0, M_rd_o},       {27'd0, exp_rd});
                chk("wen",  {31'd0, M_wen_o},      {31'd0, exp_wen});
                chk("mis",  {31'd0, M_misalign_o}, {31'd0, exp_mis});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [2:0] f3_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        int kind;
        logic [31:0] addr;
        rst_n = 1'b0;
        E_valid_i = 1'b0; E_op_load_i = 1'b0; E_op_store_i = 1'b0; E_funct3_i = 3'd0;
        E_valE_i = 32'd0; E_rs2_data_i = 32'd0; E_rd_i = 5'd0; E_wen_i = 1'b0;
        dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;

        // Pin the reference model to hand-computed values.
        chk("pin_lb",    m_ext(3'b000, 32'h202, 32'h00800000), 32'hFFFFFF80);
        chk("pin_lbu",   m_ext(3'b100, 32'h202, 32'h00800000), 32'h00000080);
        chk("pin_lhu",   m_ext(3'b101, 32'h202, 32'hBEEF0000), 32'h0000BEEF);
        chk("pin_sb_st", {28'd0, m_strb(1'b0, 3'b000, 32'h103)}, 32'h8);
        chk("pin_sb_wd", m_wdata(3'b000, 32'hAABBCCDD), 32'hDDDDDDDD);
        chk("pin_sh_st", {28'd0, m_strb(1'b0, 3'b001, 32'h102)}, 32'hC);
        chk("pin_lw_mis", {31'd0, m_misaligned(3'b010, 32'h101)}, 32'd1);

        begin_cycle();
        begin_cycle();
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        check_en = 1'b1;

        // Directed test-plan scenarios
        run_instr(1'b0, 1'b0, 3'd0, 32'h1234, 32'd0, 5'd5, 1'b1, 0, 1, 32'd0, 1'b0);
        idle_cycle(); #1;
        chk("nonmem_valid", {31'd0, M_valid_o}, 32'd1);
        chk("nonmem_vale", M_valE_o, 32'h1234);
        chk("nonmem_rd", {27'd0, M_rd_o}, 32'd5);

        run_instr(1'b0, 1'b1, 3'b000, 32'h103, 32'hAABBCCDD, 5'd0, 1'b0, 3, 1, 32'd0, 1'b0);
        run_instr(1'b1, 1'b0, 3'b000, 32'h202, 32'd0, 5'd7, 1'b1, 1, 2, 32'h00800000, 1'b0);
        idle_cycle(); #1;
        chk("lb_lit", M_valM_o, 32'hFFFFFF80);
        run_instr(1'b1, 1'b0, 3'b100, 32'h202, 32'd0, 5'd7, 1'b1, 0, 1, 32'h00800000, 1'b0);
        run_instr(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 5'd8, 1'b1, 2, 1, 32'hBEEF0000, 1'b0);
        idle_cycle(); #1;
        chk("lhu_lit", M_valM_o, 32'h0000BEEF);
        run_instr(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd9, 1'b1, 0, 1, 32'd0, 1'b0);
        idle_cycle(); #1;
        chk("lw_mis_lit", {31'd0, M_misalign_o}, 32'd1);
        chk("lw_wen_lit", {31'd0, M_wen_o}, 32'd0);
        run_instr(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000CAFE, 5'd0, 1'b0, 0, 1, 32'd0, 1'b0);
        run_instr(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 5'd3, 1'b1, 0, 5, 32'h13579BDF, 1'b0);
        run_instr(1'b0, 1'b0, 3'd0, 32'h55AA, 32'd0, 5'd4, 1'b1, 0, 1, 32'd0, 1'b0);
        run_instr(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd6, 1'b1, 0, 1, 32'hFFFFFFFF, 1'b1);
        #1;
        check_zero("abort");

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            if (kind == 0) begin
                idle_cycle();
            end else if (kind <= 3) begin
                run_instr(1'b0, 1'b0, 3'($urandom), addr, $urandom, 5'($urandom), 1'($urandom),
                          0, 1, 32'd0, 1'b0);
            end else if (kind <= 6) begin
                run_instr(1'b1, 1'b0, f3_tab[$urandom_range(0, 4)], addr, $urandom, 5'($urandom),
                          1'($urandom), $urandom_range(0, 3), $urandom_range(1, 4), $urandom, 1'b0);
            end else begin
                run_instr(1'b0, 1'b1, f3_tab[$urandom_range(0, 2)], addr, $urandom, 5'($urandom),
                          1'($urandom), $urandom_range(0, 3), 1, 32'd0, 1'b0);
            end
        end
        idle_cycle();
        idle_cycle();
        @(posedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage, directly downstream of the execute stage. It takes the execute result as the effective address for loads and stores, and as pass-through data for everything else. It runs a request/response handshake with the data memory and holds the pipeline with a stall while an access is in flight. It extends load data, then registers the result for write-back.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- E_valid_i  in  1  execute-stage instruction valid.
- E_op_load_i  in  1  the instruction is a load.
- E_op_store_i  in  1  the instruction is a store.
- E_funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- E_valE_i  in  XLEN  ALU result; the byte address for loads and stores.
- E_rs2_data_i  in  XLEN  store data.
- E_rd_i  in  5  destination register.
- E_wen_i  in  1  register write enable.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  XLEN  word address, {addr[XLEN-1:2],2'b00}.
- dmem_wstrb_o  out  4  byte strobes.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_ready_i  in  1  memory accepts the request this cycle.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  read word.
- M_stall_o  out  1  combinational; upstream must hold its E_* inputs stable while this is 1.
- M_valid_o  out  1  registered result valid.
- M_valE_o  out  XLEN  registered copy of E_valE_i.
- M_valM_o  out  XLEN  registered, extended load data.
- M_rd_o  out  5  registered destination register.
- M_wen_o  out  1  registered write enable.
- M_misalign_o  out  1  registered misaligned-access flag.

## Operation
Alignment and data formatting:
- a = E_valE_i[1:0].
- Misaligned: H/HU with a[0]=1, or W with a≠0. Bytes are never misaligned.
- A misaligned access issues no memory request. The result register loads M_misalign_o=1 and M_wen_o=0.

Store strobes and data:
- Byte: wstrb = 4'b0001<<a, wdata = {4{rs2[7:0]}}.
- Half: wstrb = 4'b0011<<a, wdata = {2{rs2[15:0]}}.
- Word: wstrb = 4'b1111, wdata = rs2.

Load extension:
- Select byte rdata[8a+7:8a] or half rdata[16a[1]+15:16a[1]].
- Sign-extend for B/H, zero-extend for BU/HU. W passes through.

Request register and FSM:
- Address, funct3, store data, rd and wen are captured into a request register on accept.
- IDLE:
  - valid non-memory instruction → result register loads {valE, valM=0, rd, wen}, M_valid_o=1; stay in IDLE.
  - valid aligned load/store → capture, go to REQ.
  - valid misaligned load/store → result register loads M_misalign_o=1, M_wen_o=0; stay in IDLE.
  - E_valid_i=0 → M_valid_o=0.
- REQ: dmem_req_o=1 with stable address, strobes and data.
  - dmem_ready_i=1 on a store → result register loads, go to IDLE.
  - dmem_ready_i=1 on a load → go to WAIT.
  - Otherwise stay in REQ.
- WAIT: dmem_req_o=0.
  - dmem_rvalid_i=1 → M_valM_o=extended data, M_valid_o=1, go to IDLE.
  - dmem_rvalid_i in REQ is ignored.

Outputs and stall:
- dmem_* outputs are driven from the request register. dmem_wstrb_o is 0 for loads; dmem_we_o is 1 only for stores.
- M_stall_o=1 when:
  - in IDLE while accepting an aligned memory op, or
  - in REQ unless this is a store with dmem_ready_i=1, or
  - in WAIT unless dmem_rvalid_i=1.
- M_valid_o is a one-cycle pulse per completed instruction. It is 0 in any cycle with no completion.

## Timing
- Reset: state IDLE; every output 0, including dmem_req_o and M_stall_o.
- Reset mid-access: the FSM returns to IDLE, the request is dropped the next cycle, and any later rvalid is ignored.
- Non-memory or misaligned instruction: result valid 1 cycle after accept.
- Store accepted at cycle N: dmem_req_o=1 from N+1. With ready at cycle R, M_valid_o=1 at R+1. Minimum latency 2.
- Load accepted at cycle N: ready at R ≥ N+1, rvalid at V ≥ R+1, M_valid_o=1 at V+1. Minimum latency 3.
- The completion cycle has M_stall_o=0, so upstream advances on that edge. The next instruction is seen in IDLE the following cycle, with no bubble beyond the access itself.
- dmem_req_o stays high and unchanged until ready. There is at most one outstanding request.

## Test plan
- Non-memory op, valE=0x1234, rd=5, wen=1 → next cycle M_valid_o=1, M_valE_o=0x1234, M_rd_o=5, M_stall_o never 1.
- SB, addr 0x103, rs2=0xAABBCCDD; ready held 0 for 3 cycles → dmem_addr_o=0x100, wstrb=1000, wdata=0xDDDDDDDD, req held 4 cycles, stall high throughout, M_valid_o one cycle after ready.
- LB at 0x202 with rdata=0x00800000 → M_valM_o=0xFFFFFF80. Same access as LBU → 0x00000080. LHU at 0x202 with rdata=0xBEEF0000 → 0x0000BEEF.
- LW at 0x101 → no dmem_req_o, M_misalign_o=1, M_wen_o=0 one cycle later. SH at 0x102 → wstrb=1100, no misalign.
- Load with rvalid 5 cycles after ready, followed immediately by a non-memory op → stall high until the rvalid cycle, load result then non-memory result on consecutive cycles.
- rst_n low during WAIT, then a stray rvalid → all outputs 0, FSM in IDLE, no M_valid_o pulse.
